mii_tx_frame: RTL

//  MII (100M, 4-bit) Ethernet frame transmitter; transmit-side counterpart of the E_RX_* receive path.

---
 rtl/mii_tx_pkg.sv | 25 ++
 rtl/mii_tx_frame_crc.sv | 26 ++
 rtl/mii_tx_frame.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mii_tx_pkg.sv
// Shared types and constants for the MII frame transmitter.
package mii_tx_pkg;

  // Transmit FSM states; each state describes the nibble currently on the wire.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_DATA = 3'd2,
    S_PAD  = 3'd3,
    S_FCS  = 3'd4,
    S_IFG  = 3'd5,
    S_ERR  = 3'd6
  } tx_state_e;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_HI_NIB   = 4'hD;
  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;

  // Width of the shared preamble / FCS / IFG nibble counter.
  localparam int CNT_W  = 8;
  // Width of the saturating payload+pad byte counter.
  localparam int BCNT_W = 11;

endpackage

// File: rtl/mii_tx_frame_crc.sv
// Combinational reflected CRC-32 step over one nibble (LSB first).
module crc32_nibble
  import mii_tx_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [3:0]  i_nib,
  output logic [31:0] o_crc
);

  logic [31:0] w_acc;

  // Four reflected shift/xor steps, one per nibble bit.
  always_comb begin
    w_acc = i_crc ^ {28'd0, i_nib};
    for (int k = 0; k < 4; k++) begin
      if (w_acc[0]) begin
        w_acc = (w_acc >> 1) ^ CRC_POLY;
      end else begin
        w_acc = w_acc >> 1;
      end
    end
  end

  assign o_crc = w_acc;

endmodule

// File: rtl/mii_tx_frame.sv
// MII (4-bit) Ethernet transmitter: preamble/SFD, payload, zero pad,
// CRC-32 FCS and inter-frame gap, fed from a valid/ready/last byte stream.
// The FSM registers describe the nibble currently on the pins; the pin
// registers are loaded from the decoded next state so they line up.
module mii_tx_frame
  import mii_tx_pkg::*;
#(
  parameter int MIN_LEN = 60,
  parameter int IFG_NIB = 24,
  parameter int PRE_NIB = 15
) (
  input  logic       E_TX_CLK,
  input  logic       RST_N,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       E_TX_EN,
  output logic [3:0] E_TXD,
  output logic       E_TX_ER,
  output logic       busy,
  output logic       underrun
);

  localparam logic [CNT_W-1:0]  PRE_CNT   = CNT_W'(PRE_NIB);
  localparam logic [CNT_W-1:0]  IFG_LAST  = CNT_W'(IFG_NIB - 1);
  localparam logic [CNT_W-1:0]  FCS_LAST  = 8'd7;
  localparam logic [BCNT_W:0]   MIN_LEN_W = (BCNT_W + 1)'(MIN_LEN);

  tx_state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_phase, w_phase_nxt;
  logic [7:0]         r_byte, w_byte_nxt;
  logic               r_last, w_last_nxt;
  logic [BCNT_W-1:0]  r_bytes, w_bytes_nxt, w_bytes_inc;
  logic [31:0]        r_crc, w_crc_nxt, w_crc_upd, w_fcs;
  logic [3:0]         w_cur_nib;

  logic               r_tx_en, r_tx_er, r_underrun;
  logic [3:0]         r_txd;
  logic               w_en_nxt, w_er_nxt, w_ur_nxt;
  logic [3:0]         w_txd_nxt;

  // Nibble currently leaving the block while the CRC is accumulating.
  always_comb begin
    if (r_state == S_DATA) begin
      w_cur_nib = r_phase ? r_byte[7:4] : r_byte[3:0];
    end else begin
      w_cur_nib = 4'h0;
    end
  end

  crc32_nibble u_crc (
    .i_crc (r_crc),
    .i_nib (w_cur_nib),
    .o_crc (w_crc_upd)
  );

  assign w_bytes_inc = (r_bytes == {BCNT_W{1'b1}}) ? r_bytes : r_bytes + 11'd1;

  // State and datapath registers.
  always_ff @(posedge E_TX_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_byte  <= 8'h00;
      r_last  <= 1'b0;
      r_bytes <= '0;
      r_crc   <= CRC_INIT;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
      r_byte  <= w_byte_nxt;
      r_last  <= w_last_nxt;
      r_bytes <= w_bytes_nxt;
      r_crc   <= w_crc_nxt;
    end
  end

  // Next-state logic: frame sequencing, byte acceptance, padding and CRC update.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    w_byte_nxt  = r_byte;
    w_last_nxt  = r_last;
    w_bytes_nxt = r_bytes;
    w_crc_nxt   = r_crc;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = S_PRE;
          w_cnt_nxt   = '0;
          w_crc_nxt   = CRC_INIT;
          w_bytes_nxt = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PRE: begin
        if (r_cnt != PRE_CNT) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end else if (in_valid) begin
          // SFD cycle: the first payload byte is taken here.
          w_state_nxt = S_DATA;
          w_phase_nxt = 1'b0;
          w_byte_nxt  = in_data;
          w_last_nxt  = in_last;
          w_bytes_nxt = 11'd1;
        end else begin
          w_state_nxt = S_ERR;
        end
      end
      S_DATA: begin
        w_crc_nxt = w_crc_upd;
        if (!r_phase) begin
          w_phase_nxt = 1'b1;
        end else if (!r_last) begin
          if (in_valid) begin
            w_phase_nxt = 1'b0;
            w_byte_nxt  = in_data;
            w_last_nxt  = in_last;
            w_bytes_nxt = w_bytes_inc;
          end else begin
            w_state_nxt = S_ERR;
          end
        end else if ({1'b0, r_bytes} < MIN_LEN_W) begin
          w_state_nxt = S_PAD;
          w_phase_nxt = 1'b0;
        end else begin
          w_state_nxt = S_FCS;
          w_cnt_nxt   = '0;
        end
      end
      S_PAD: begin
        w_crc_nxt = w_crc_upd;
        if (!r_phase) begin
          w_phase_nxt = 1'b1;
        end else begin
          w_phase_nxt = 1'b0;
          w_bytes_nxt = w_bytes_inc;
          if ({1'b0, w_bytes_inc} >= MIN_LEN_W) begin
            w_state_nxt = S_FCS;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_PAD;
          end
        end
      end
      S_FCS: begin
        if (r_cnt == FCS_LAST) begin
          w_state_nxt = S_IFG;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_IFG: begin
        if (r_cnt == IFG_LAST) begin
          // Last gap nibble doubles as the idle sample so back-to-back
          // frames keep exactly IFG_NIB idle cycles.
          if (in_valid) begin
            w_state_nxt = S_PRE;
            w_cnt_nxt   = '0;
            w_crc_nxt   = CRC_INIT;
            w_bytes_nxt = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_ERR: begin
        w_state_nxt = S_IFG;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_fcs = ~w_crc_nxt;

  // Output decode of the nibble that the next state will place on the pins.
  always_comb begin
    w_en_nxt  = 1'b0;
    w_er_nxt  = 1'b0;
    w_ur_nxt  = 1'b0;
    w_txd_nxt = 4'h0;
    case (w_state_nxt)
      S_PRE: begin
        w_en_nxt  = 1'b1;
        w_txd_nxt = (w_cnt_nxt == PRE_CNT) ? SFD_HI_NIB : PREAMBLE_NIB;
      end
      S_DATA: begin
        w_en_nxt  = 1'b1;
        w_txd_nxt = w_phase_nxt ? w_byte_nxt[7:4] : w_byte_nxt[3:0];
      end
      S_PAD: begin
        w_en_nxt = 1'b1;
      end
      S_FCS: begin
        w_en_nxt  = 1'b1;
        w_txd_nxt = w_fcs[{w_cnt_nxt[2:0], 2'b00} +: 4];
      end
      S_ERR: begin
        w_en_nxt = 1'b1;
        w_er_nxt = 1'b1;
        w_ur_nxt = 1'b1;
      end
      default: begin
        w_en_nxt = 1'b0;
      end
    endcase
  end

  // PHY pin and status registers.
  always_ff @(posedge E_TX_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_tx_en    <= 1'b0;
      r_txd      <= 4'h0;
      r_tx_er    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_tx_en    <= w_en_nxt;
      r_txd      <= w_txd_nxt;
      r_tx_er    <= w_er_nxt;
      r_underrun <= w_ur_nxt;
    end
  end

  assign E_TX_EN  = r_tx_en;
  assign E_TXD    = r_txd;
  assign E_TX_ER  = r_tx_er;
  assign underrun = r_underrun;
  assign busy     = (r_state != S_IDLE);
  assign in_ready = ((r_state == S_PRE) && (r_cnt == PRE_CNT)) ||
                    ((r_state == S_DATA) && r_phase && !r_last);

endmodule
